// File: rtl/morse_decoder_pkg.sv
// Shared types and default timing constants for the Morse decoding path.
//   sym_t   : symbol code carried from the symbol FSM to the character decoder
//   state_t : symbol FSM state encoding
package morse_decoder_pkg;

  localparam int unsigned UNIT_CYCLES_C      = 12_500_000;
  localparam int unsigned DASH_UNITS_C       = 3;
  localparam int unsigned LETTER_GAP_UNITS_C = 3;
  localparam int unsigned WORD_GAP_UNITS_C   = 7;

  typedef enum logic [1:0] {
    DOT        = 2'd0,
    DASH       = 2'd1,
    LETTER_END = 2'd2,
    WORD_END   = 2'd3
  } sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/unit_timer.sv
// Dot-unit timer: a prescaler that divides clk down to dot-units plus a
// unit counter that saturates at MAX. Both restart on clear.
//   clk, resetn : clock, synchronous active-low reset
//   clear       : restart timing; the clearing cycle counts as prescaler phase 0
//   unit_tick   : high for the one cycle in which units has just incremented
//   units       : whole dot-units elapsed since the last clear (saturating)
module unit_timer #(
  parameter int unsigned UNIT_CYCLES = 4,
  parameter int unsigned MAX         = 7,
  parameter int unsigned UNITS_W     = $clog2(MAX + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  output logic               unit_tick,
  output logic [UNITS_W-1:0] units
);

  localparam int unsigned PRESC_W = $clog2(UNIT_CYCLES);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_d;
  logic [UNITS_W-1:0] units_d;
  logic               wrap;
  logic               tick_d;

  // The clearing cycle is phase 0, so the prescaler resumes at phase 1.
  always_comb begin
    wrap    = !clear && (presc == PRESC_W'(UNIT_CYCLES - 1));
    presc_d = presc + PRESC_W'(1);
    if (clear) begin
      presc_d = PRESC_W'(1);
    end else if (wrap) begin
      presc_d = '0;
    end
    tick_d  = wrap && (units < UNITS_W'(MAX));
    units_d = units;
    if (clear) begin
      units_d = '0;
    end else if (tick_d) begin
      units_d = units + UNITS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc     <= '0;
      units     <= '0;
      unit_tick <= 1'b0;
    end else begin
      presc     <= presc_d;
      units     <= units_d;
      unit_tick <= tick_d;
    end
  end

endmodule

// File: rtl/morse_symbol_fsm.sv
// Turns the debounced button level into Morse symbols (DOT, DASH,
// LETTER_END, WORD_END) by timing presses and gaps in dot-units, and
// presents them on a single-entry valid/ready output register.
//   clk, resetn  : clock, synchronous active-low reset
//   db_btn_i     : debounced button level, synchronous to clk
//   sym_ready_i  : consumer accepts sym_o when high with sym_valid_o
//   sym_valid_o  : sym_o holds a symbol
//   sym_o        : symbol code (sym_t)
//   overflow_o   : sticky, a symbol was dropped because the stage was full
//   busy_o       : FSM is not in IDLE
module morse_symbol_fsm
  import morse_decoder_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES      = UNIT_CYCLES_C,
  parameter int unsigned DASH_UNITS       = DASH_UNITS_C,
  parameter int unsigned LETTER_GAP_UNITS = LETTER_GAP_UNITS_C,
  parameter int unsigned WORD_GAP_UNITS   = WORD_GAP_UNITS_C
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       db_btn_i,
  input  logic       sym_ready_i,
  output logic       sym_valid_o,
  output logic [1:0] sym_o,
  output logic       overflow_o,
  output logic       busy_o
);

  localparam int unsigned UNITS_W = $clog2(WORD_GAP_UNITS + 1);

  state_t             state;
  state_t             state_d;
  logic               prev_btn;
  logic               rise;
  logic               fall;
  logic               unit_tick;
  logic [UNITS_W-1:0] units;
  logic               emit;
  sym_t               emit_sym;
  logic               load;
  logic               valid_d;
  sym_t               sym_d;
  logic               overflow_d;
  logic               busy_d;

  // Edges against the registered level; prev_btn resets low, so a button
  // held through reset shows up as a rise on the first active cycle.
  assign rise = db_btn_i && !prev_btn;
  assign fall = !db_btn_i && prev_btn;

  unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES),
    .MAX         (WORD_GAP_UNITS),
    .UNITS_W     (UNITS_W)
  ) u_unit_timer (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (rise || fall),
    .unit_tick (unit_tick),
    .units     (units)
  );

  // Next state, symbol generation and output-stage update.
  always_comb begin
    state_d  = state;
    emit     = 1'b0;
    emit_sym = DOT;

    unique case (state)
      IDLE: begin
        if (rise) state_d = PRESS;
      end
      PRESS: begin
        if (fall) begin
          emit     = 1'b1;
          emit_sym = (units >= UNITS_W'(DASH_UNITS)) ? DASH : DOT;
          state_d  = GAP;
        end
      end
      GAP: begin
        // unit_tick marks the single cycle a count is first reached, which
        // makes each gap symbol fire once per gap.
        if (unit_tick && (units == UNITS_W'(WORD_GAP_UNITS))) begin
          emit     = 1'b1;
          emit_sym = WORD_END;
          state_d  = IDLE;
        end else if (unit_tick && (units == UNITS_W'(LETTER_GAP_UNITS))) begin
          emit     = 1'b1;
          emit_sym = LETTER_END;
        end
        // A rise on the threshold cycle still keeps the threshold symbol.
        if (rise) state_d = PRESS;
      end
      default: state_d = IDLE;
    endcase

    load       = emit && (!sym_valid_o || sym_ready_i);
    valid_d    = load || (sym_valid_o && !sym_ready_i);
    sym_d      = load ? emit_sym : sym_t'(sym_o);
    overflow_d = overflow_o || (emit && !load);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      prev_btn    <= 1'b0;
      sym_valid_o <= 1'b0;
      sym_o       <= DOT;
      overflow_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_d;
      prev_btn    <= db_btn_i;
      sym_valid_o <= valid_d;
      sym_o       <= sym_d;
      overflow_o  <= overflow_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_morse_symbol_fsm.sv
// Scoreboard bench for morse_symbol_fsm at UNIT_CYCLES=4: stimulus pushes
// expected (symbol, cycle) pairs, a monitor pops them on every handshake.
module tb_morse_symbol_fsm;
  import morse_decoder_pkg::*;

  localparam int unsigned UC = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       db_btn = 1'b0;
  logic       sym_ready = 1'b0;
  logic       sym_valid;
  logic [1:0] sym;
  logic       overflow;
  logic       busy;

  morse_symbol_fsm #(
    .UNIT_CYCLES (UC)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .db_btn_i    (db_btn),
    .sym_ready_i (sym_ready),
    .sym_valid_o (sym_valid),
    .sym_o       (sym),
    .overflow_o  (overflow),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] s;
    int         at;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, expv, cyc);
  endtask

  task automatic push(input logic [1:0] s, input int at);
    exp_t e;
    e.s  = s;
    e.at = at;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic at_neg(input int c);
    wait_to(c);
    @(negedge clk);
  endtask

  // Monitor: every accepted symbol must match the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && sym_valid && sym_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL extra_symbol: got sym %0d at cycle %0d, expected none", sym, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sym_code", int'(sym), int'(e.s));
        check("sym_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int r;
    int f;
    int f2;
    int p;
    int qc;

    // Reset values
    resetn = 1'b0; db_btn = 1'b0; sym_ready = 1'b1;
    step(2);
    @(negedge clk);
    check("rst_valid", sym_valid, 0);
    check("rst_sym", sym, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    step(1);
    resetn = 1'b1;
    step(2);

    // 5-cycle press -> DOT at R+1 for one cycle; then LETTER_END, WORD_END
    db_btn = 1'b1; step(5);
    db_btn = 1'b0; r = cyc;
    push(DOT, r + 1); push(LETTER_END, r + 13); push(WORD_END, r + 29);
    at_neg(r + 1);
    check("dot_valid", sym_valid, 1);
    at_neg(r + 2);
    check("dot_one_cycle", sym_valid, 0);
    check("dot_overflow", overflow, 0);
    at_neg(r + 28);
    check("busy_before_word", busy, 1);
    at_neg(r + 29);
    check("busy_after_word", busy, 0);
    wait_to(r + 32);

    // 12-cycle press -> DASH; 11-cycle gap then press -> no LETTER_END
    db_btn = 1'b1; step(12);
    db_btn = 1'b0; r = cyc;
    push(DASH, r + 1);
    wait_to(r + 11);
    db_btn = 1'b1;
    at_neg(r + 11);
    check("busy_in_gap", busy, 1);
    wait_to(r + 15);
    // 4-cycle press, release held low -> DOT, LETTER_END @+13, WORD_END @+29
    db_btn = 1'b0; f = cyc;
    push(DOT, f + 1); push(LETTER_END, f + 13); push(WORD_END, f + 29);
    at_neg(f + 12);
    check("no_early_letter", sym_valid, 0);
    check("busy_gap2", busy, 1);
    at_neg(f + 29);
    check("idle_after_word", busy, 0);
    wait_to(f + 32);

    // Rise exactly on the LETTER_END threshold cycle
    db_btn = 1'b1; step(4);
    db_btn = 1'b0; f = cyc;
    push(DOT, f + 1);
    wait_to(f + 12);
    db_btn = 1'b1;
    push(LETTER_END, f + 13);
    at_neg(f + 13);
    check("busy_thresh_rise", busy, 1);
    wait_to(f + 16);
    db_btn = 1'b0; f2 = cyc;
    push(DOT, f2 + 1); push(LETTER_END, f2 + 13); push(WORD_END, f2 + 29);
    wait_to(f2 + 32);

    // Consumer stalled: first DOT held, DASH dropped, overflow sticky
    sym_ready = 1'b0;
    db_btn = 1'b1; step(4);
    db_btn = 1'b0; f = cyc;
    at_neg(f + 1);
    check("stall_valid", sym_valid, 1);
    check("stall_sym", sym, 0);
    check("stall_no_ovf", overflow, 0);
    wait_to(f + 4);
    db_btn = 1'b1;
    wait_to(f + 16);
    db_btn = 1'b0; f2 = cyc;
    @(negedge clk);
    check("pre_drop_ovf", overflow, 0);
    at_neg(f2 + 1);
    check("drop_ovf", overflow, 1);
    check("drop_sym_held", sym, 0);
    check("drop_valid", sym_valid, 1);
    at_neg(f2 + 40);
    check("ovf_sticky", overflow, 1);
    check("held_sym_late", sym, 0);
    check("idle_stalled", busy, 0);
    step(1);
    p = cyc;
    push(DOT, p);
    sym_ready = 1'b1;
    at_neg(p + 1);
    check("drain_valid_low", sym_valid, 0);
    check("ovf_still_set", overflow, 1);
    step(2);

    // Reset for one cycle mid-press, with a symbol pending and overflow set
    sym_ready = 1'b0;
    db_btn = 1'b1; step(4);
    db_btn = 1'b0; f = cyc;
    at_neg(f + 2);
    check("pending_before_rst", sym_valid, 1);
    wait_to(f + 4);
    db_btn = 1'b1;
    step(3);
    resetn = 1'b0; qc = cyc;
    step(1);
    resetn = 1'b1; sym_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", sym_valid, 0);
    check("mid_rst_sym", sym, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_busy", busy, 0);
    wait_to(qc + 6);
    db_btn = 1'b0; f = cyc;
    push(DOT, f + 1); push(LETTER_END, f + 13); push(WORD_END, f + 29);
    at_neg(f + 2);
    check("post_rst_busy", busy, 1);
    wait_to(f + 34);

    check("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
